// File: rtl/par_rx_handshake_if.sv
// Signal bundle between the parallel-link receive controller and its surroundings:
// the remote-side request/data/ack and the downstream valid/ready word port plus error flags.
interface par_rx_handshake_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              req_sync;
    logic [DATA_W-1:0] rx_data;
    logic              ack_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              err_clr;
    logic              glitch_err;
    logic              timeout_err;
    logic [CNT_W-1:0]  frame_cnt;

    // slave: the receive controller itself
    modport slave (
        input  req_sync, rx_data, out_ready, err_clr,
        output ack_out, out_data, out_valid, glitch_err, timeout_err, frame_cnt
    );

    // master: transmitter model and downstream consumer
    modport master (
        output req_sync, rx_data, out_ready, err_clr,
        input  ack_out, out_data, out_valid, glitch_err, timeout_err, frame_cnt
    );
endinterface

// File: rtl/par_rx_handshake.sv
// Receive-side 4-phase handshake controller: waits for a settled request, captures the
// parallel bus, acknowledges the transmitter and offers the word on a valid/ready port.
module par_rx_handshake #(
    parameter int DATA_W      = 8,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk_dest,
    input  logic              rst_dest,
    par_rx_handshake_if.slave bus,
    output logic [1:0]        state_dbg
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACK_HI = 2'd2
    } state_t;

    state_t             state;
    logic [SET_W-1:0]   settle_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    assign state_dbg = state;

    // Downstream port: a word transfers on any edge where out_valid && out_ready are both 1;
    // out_valid then drops and out_data holds until the next capture. out_valid never
    // depends on out_ready, and the consumer may stall indefinitely.
    always_ff @(posedge clk_dest) begin
        if (rst_dest) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            tmo_cnt         <= '0;
            bus.ack_out     <= 1'b0;
            bus.out_data    <= '0;
            bus.out_valid   <= 1'b0;
            bus.glitch_err  <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.frame_cnt   <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;

            // Clear first so an error event later in this block overrides it
            if (bus.err_clr) begin
                bus.glitch_err  <= 1'b0;
                bus.timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bus.ack_out <= 1'b0;
                    // Gate uses the registered out_valid: a same-cycle consume opens it next cycle
                    if (bus.req_sync && !bus.out_valid) begin
                        state      <= SETTLE;
                        settle_cnt <= SET_W'(SETTLE_CYC - 1);
                    end
                end

                SETTLE: begin
                    if (!bus.req_sync) begin
                        state          <= IDLE;
                        bus.glitch_err <= 1'b1;
                    end else if (settle_cnt == '0) begin
                        bus.out_data  <= bus.rx_data;
                        bus.out_valid <= 1'b1;
                        bus.ack_out   <= 1'b1;
                        bus.frame_cnt <= bus.frame_cnt + CNT_W'(1);
                        tmo_cnt       <= '0;
                        state         <= ACK_HI;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end

                ACK_HI: begin
                    if (!bus.req_sync) begin
                        bus.ack_out <= 1'b0;
                        state       <= IDLE;
                    end else if (tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
                        // Flag only on the step that reaches the limit; ack is never forced low
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))
                            bus.timeout_err <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
